// File: rtl/ps2_arrow_key_decoder_pkg.sv
// Shared scan codes and state encodings for the PS/2 arrow-key decoder.
package ps2_arrow_key_decoder_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit counter value at which the stop bit is the current sample
  localparam logic [3:0] LAST_BIT = 4'd10;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_EXT,
    D_BRK,
    D_EXTBRK
  } dec_state_e;

endpackage

// File: rtl/ps2_arrow_key_decoder_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, falling-edge
// sample strobe, 11-bit frame FSM with parity/stop checks and a stall timeout.
module ps2_frame_rx
  import ps2_arrow_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN    = 8,
  parameter int FRAME_TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(FRAME_TIMEOUT - 1);

  logic          ps2_clk_p0, ps2_clk_p1;
  logic          ps2_data_p0, ps2_data_p1;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          sample;

  rx_state_e     state, state_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [8:0]    shreg, shreg_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]    byte_nxt;
  logic          valid_nxt, err_nxt;

  // Odd parity over D0..D7+P and a high stop bit
  function automatic logic frame_ok(input logic [8:0] bits, input logic stop);
    return (^bits) & stop;
  endfunction

  // ---- stage p0/p1: pin synchronisers (idle bus is high)
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // ---- glitch filter: level follows only after FILTER_LEN differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (ps2_clk_p1 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_clk <= ps2_clk_p1;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Strobe on the cycle the filtered clock is about to fall
  assign sample = filt_clk & ~ps2_clk_p1 & (filt_cnt == FILT_LAST);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    byte_nxt    = rx_byte;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    if (sample || state == RX_IDLE) to_cnt_nxt = '0;
    else                            to_cnt_nxt = to_cnt + 1'b1;

    case (state)
      RX_IDLE: begin
        if (sample && !ps2_data_p1) begin
          state_nxt   = RX_SHIFT;
          bit_cnt_nxt = 4'd1;
        end
      end
      RX_SHIFT: begin
        if (sample) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = RX_IDLE;
            if (frame_ok(shreg, ps2_data_p1)) begin
              byte_nxt  = shreg[7:0];
              valid_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            shreg_nxt   = {ps2_data_p1, shreg[8:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          state_nxt = RX_IDLE;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // ---- stage p2: frame state and registered byte/strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      to_cnt    <= to_cnt_nxt;
      rx_byte   <= byte_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

endmodule

// File: rtl/ps2_arrow_key_decoder.sv
// PS/2 arrow-key decoder: turns extended LEFT/RIGHT make codes into
// one-cycle key pulses; releases and all other keys are swallowed.
module ps2_arrow_key_decoder
  import ps2_arrow_key_decoder_pkg::*;
#(
  parameter int         FILTER_LEN    = 8,
  parameter int         FRAME_TIMEOUT = 200000,
  parameter logic [7:0] LEFT_CODE     = SC_LEFT,
  parameter logic [7:0] RIGHT_CODE    = SC_RIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left_key,
  output logic       right_key,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  dec_state_e dec_state, dec_state_nxt;
  logic       left_nxt, right_nxt;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .FRAME_TIMEOUT (FRAME_TIMEOUT)
  ) u_frame_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // A bad frame drops any pending prefix so it cannot pair with a later byte
  always_comb begin
    dec_state_nxt = dec_state;
    left_nxt      = 1'b0;
    right_nxt     = 1'b0;
    if (frame_err) begin
      dec_state_nxt = D_IDLE;
    end else if (rx_valid) begin
      case (dec_state)
        D_IDLE: begin
          if (rx_byte == SC_EXT)      dec_state_nxt = D_EXT;
          else if (rx_byte == SC_BRK) dec_state_nxt = D_BRK;
        end
        D_EXT: begin
          if (rx_byte == SC_BRK) begin
            dec_state_nxt = D_EXTBRK;
          end else begin
            dec_state_nxt = D_IDLE;
            left_nxt      = (rx_byte == LEFT_CODE);
            right_nxt     = (rx_byte == RIGHT_CODE);
          end
        end
        D_BRK, D_EXTBRK: dec_state_nxt = D_IDLE;
        default:         dec_state_nxt = D_IDLE;
      endcase
    end
  end

  // ---- stage p3: decoder state and registered key pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state <= D_IDLE;
      left_key  <= 1'b0;
      right_key <= 1'b0;
    end else begin
      dec_state <= dec_state_nxt;
      left_key  <= left_nxt;
      right_key <= right_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_arrow_key_decoder.sv
// Self-checking bench: PS/2 frames (directed and random) against a byte-stream
// parser model of make/break/extended sequences.
module tb_ps2_arrow_key_decoder;

  localparam int FILTER_LEN    = 4;
  localparam int FRAME_TIMEOUT = 2000;
  localparam int BIT_PER       = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       left_key, right_key, rx_valid, frame_err;
  logic [7:0] rx_byte;

  ps2_arrow_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .FRAME_TIMEOUT (FRAME_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .left_key  (left_key),
    .right_key (right_key),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event history since the last reset: good byte value, or -1 for a bad frame
  int         hist[$];
  logic [7:0] last_good = 8'h00;

  int          got_valid, got_err, got_left, got_right;
  logic [31:0] got_sig;
  logic        prev_valid;
  logic [7:0]  prev_byte;

  always @(negedge clk) begin
    if (reset) begin
      got_valid = 0; got_err = 0; got_left = 0; got_right = 0;
      got_sig = 0; prev_valid = 1'b0;
    end else begin
      if (left_key || right_key) begin
        check_eq("key_exclusive", {31'b0, left_key & right_key}, 32'd0);
        check_eq("key_after_valid", {31'b0, prev_valid}, 32'd1);
        check_eq("key_code", {24'b0, prev_byte}, left_key ? 32'h6B : 32'h74);
        if (left_key) begin got_left++;  got_sig = got_sig * 3 + 1; end
        else          begin got_right++; got_sig = got_sig * 3 + 2; end
      end
      if (rx_valid)  got_valid++;
      if (frame_err) got_err++;
      prev_valid = rx_valid;
      prev_byte  = rx_byte;
    end
  end

  // Parse the byte stream as keyboard sequences: E0 x, E0 F0 x, F0 x, single bytes.
  task automatic model(output int e_valid, output int e_err, output int e_left,
                       output int e_right, output logic [31:0] e_sig);
    int n;
    int i;
    n = hist.size();
    i = 0;
    e_valid = 0; e_err = 0; e_left = 0; e_right = 0; e_sig = 0;
    foreach (hist[k]) if (hist[k] < 0) e_err++; else e_valid++;
    while (i < n) begin
      if (hist[i] < 0) begin
        i++;
      end else if (hist[i] == 'hE0 && i + 1 < n && hist[i+1] >= 0) begin
        if (hist[i+1] == 'hF0) begin
          i += 2;
          if (i < n && hist[i] >= 0) i++;
        end else begin
          if (hist[i+1] == 'h6B) begin e_left++;  e_sig = e_sig * 3 + 1; end
          if (hist[i+1] == 'h74) begin e_right++; e_sig = e_sig * 3 + 2; end
          i += 2;
        end
      end else if (hist[i] == 'hF0) begin
        i++;
        if (i < n && hist[i] >= 0) i++;
      end else begin
        i++;
      end
    end
  endtask

  task automatic checkpoint(input string tag);
    int ev, ee, el, er;
    logic [31:0] es;
    repeat (150) @(posedge clk);
    model(ev, ee, el, er, es);
    check_eq({tag, "/rx_valid_cnt"},  got_valid, ev);
    check_eq({tag, "/frame_err_cnt"}, got_err, ee);
    check_eq({tag, "/left_cnt"},      got_left, el);
    check_eq({tag, "/right_cnt"},     got_right, er);
    check_eq({tag, "/key_order"},     got_sig, es);
    check_eq({tag, "/rx_byte"},       {24'b0, rx_byte}, {24'b0, last_good});
  endtask

  // Drive one frame; nbits < 11 truncates it, glitch_bit adds a short low spike
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      ps2_data = bits[k];
      repeat (BIT_PER / 4) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (BIT_PER / 2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (BIT_PER / 4) @(posedge clk);
      if (k == glitch_bit) begin
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
      end
    end
    ps2_data = 1'b1;
    repeat (60) @(posedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1);
    hist.push_back(int'(b));
    last_good = b;
  endtask

  task automatic send_bad(input logic [7:0] b, input bit stop_err);
    send_frame(b, ~stop_err, stop_err, 11, -1);
    hist.push_back(-1);
  endtask

  task automatic send_stalled(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 3, -1);
    repeat (FRAME_TIMEOUT + 200) @(posedge clk);
    hist.push_back(-1);
  endtask

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, "/left_key"},  {31'b0, left_key}, 32'd0);
    check_eq({tag, "/right_key"}, {31'b0, right_key}, 32'd0);
    check_eq({tag, "/rx_valid"},  {31'b0, rx_valid}, 32'd0);
    check_eq({tag, "/frame_err"}, {31'b0, frame_err}, 32'd0);
    check_eq({tag, "/rx_byte"},   {24'b0, rx_byte}, 32'd0);
  endtask

  initial begin
    logic [7:0] pool [6];
    pool = '{8'hE0, 8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C};

    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs_idle("reset");
    reset = 1'b0;
    repeat (20) @(posedge clk);

    send_good(8'hE0); send_good(8'h6B);
    checkpoint("left_make");

    send_good(8'hE0); send_good(8'h74);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h74);
    checkpoint("right_make_release");

    send_bad(8'h6B, 1'b0);
    checkpoint("parity_err");
    send_good(8'hE0); send_good(8'h6B);
    checkpoint("after_parity_err");

    send_good(8'hE0);
    send_stalled(8'h6B);
    send_good(8'h6B);
    checkpoint("timeout_clears_prefix");

    send_good(8'h6B); send_good(8'h74);
    checkpoint("keypad_no_pulse");

    send_frame(8'hE0, 1'b0, 1'b0, 11, 4); hist.push_back('hE0); last_good = 8'hE0;
    send_frame(8'h6B, 1'b0, 1'b0, 11, 7); hist.push_back('h6B); last_good = 8'h6B;
    checkpoint("glitch_ignored");

    send_bad(8'h74, 1'b1);
    send_good(8'h74);
    checkpoint("stop_err");

    // Reset mid-sequence and mid-frame: nothing may surface from the lost sequence
    send_good(8'hE0);
    send_frame(8'h74, 1'b0, 1'b0, 5, -1);
    @(negedge clk);
    reset = 1'b1;
    hist.delete();
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_idle("mid_reset");
    reset = 1'b0;
    repeat (200) @(posedge clk);
    checkpoint("after_reset_quiet");
    send_good(8'hE0); send_good(8'h74);
    checkpoint("after_reset");

    for (int r = 0; r < 30; r++) begin
      int sel;
      logic [7:0] b;
      sel = int'($urandom_range(0, 9));
      b = (sel == 9) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 5)];
      if (sel == 0)      send_bad(b, 1'b0);
      else if (sel == 1) send_bad(b, 1'b1);
      else               send_good(b);
      if (r % 6 == 5) checkpoint("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
